// File: rtl/turing_dec_if.sv
// Bus bundle for turing_dec: load/start controls, tape image and status outputs.
// The optional `step` signal exists only when TURING_STEP_EN is defined.
interface turing_dec_if #(
    parameter int TAPE_W = 10
);
    logic              load;
    logic              start;
    logic [TAPE_W-1:0] tape_in;
    logic              busy;
    logic              done;
    logic              underflow;
    logic [7:0]        steps;
    logic [TAPE_W-1:0] tape_out;
`ifdef TURING_STEP_EN
    logic              step;

    modport master (output load, start, tape_in, step,
                    input  busy, done, underflow, steps, tape_out);
    modport slave  (input  load, start, tape_in, step,
                    output busy, done, underflow, steps, tape_out);
`else
    modport master (output load, start, tape_in,
                    input  busy, done, underflow, steps, tape_out);
    modport slave  (input  load, start, tape_in,
                    output busy, done, underflow, steps, tape_out);
`endif
endinterface

// File: rtl/turing_dec.sv
// Single-tape Turing-machine decrementer: tape - 1 (mod 2^TAPE_W), LSB-first, then rewind.
// Define TURING_STEP_EN to add a `step` qualifier that gates SCAN/REWIND progress.
//
// state  | meaning
// IDLE   | waiting for load or start
// SCAN   | processing cell head, moving toward the MSB
// REWIND | moving head back toward cell 0
// DONE   | single-cycle completion, done pulse
module turing_dec #(
    parameter int TAPE_W = 10,
    parameter int HEAD_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    turing_dec_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REWIND, S_DONE} state_t;

    localparam logic [HEAD_W-1:0] LAST = HEAD_W'(TAPE_W - 1);

    state_t            state_q, state_d;
    logic [HEAD_W-1:0] head_q, head_d;
    logic [TAPE_W-1:0] tape_q, tape_d;
    logic [7:0]        steps_q, steps_d, steps_inc;
    logic              uf_q, uf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              adv;

`ifdef TURING_STEP_EN
    assign adv = bus.step;
`else
    assign adv = 1'b1;
`endif

    assign steps_inc = (steps_q == 8'hFF) ? steps_q : steps_q + 8'd1;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tape_d  = tape_q;
        steps_d = steps_q;
        uf_d    = uf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    tape_d = bus.tape_in;
                end else if (bus.start) begin
                    head_d  = '0;
                    steps_d = '0;
                    uf_d    = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (adv) begin
                    steps_d = steps_inc;
                    if (tape_q[head_q]) begin
                        tape_d[head_q] = 1'b0;
                        state_d = (head_q == '0) ? S_DONE : S_REWIND;
                    end else begin
                        tape_d[head_q] = 1'b1;
                        if (head_q == LAST) begin
                            uf_d    = 1'b1;
                            state_d = S_REWIND;
                        end else begin
                            head_d = head_q + 1'b1;
                        end
                    end
                end
            end
            S_REWIND: begin
                // REWIND is only entered with head > 0, so head = 1 is the last move.
                if (adv) begin
                    steps_d = steps_inc;
                    head_d  = head_q - 1'b1;
                    if (head_q == HEAD_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tape_q  <= '0;
            steps_q <= '0;
            uf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tape_q  <= tape_d;
            steps_q <= steps_d;
            uf_q    <= uf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.underflow = uf_q;
    assign bus.steps     = steps_q;
    assign bus.tape_out  = tape_q;
endmodule

// File: tb/tb_turing_dec.sv
// Self-checking bench for turing_dec: directed scenarios plus random tapes against
// an arithmetic model (tape - 1, lowest-set-bit latency formula).
module tb_turing_dec;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    turing_dec_if #(.TAPE_W(W)) bus ();

    turing_dec #(.TAPE_W(W), .HEAD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // kind: 0 plain, 1 inject load/start mid-run, 2 assert reset mid-run
    task automatic run(input logic [W-1:0] t, input int kind, input int period);
        logic [W-1:0] exp_t;
        logic [W-1:0] obs2;
        logic [W-1:0] prev_tape;
        logic [7:0]   prev_steps;
        bit           prev_step;
        bit           uf;
        int           k, exp_steps, n, busy_cnt;

        exp_t = t - 1'b1;
        uf    = (t == '0);
        k     = W;
        for (int i = W - 1; i >= 0; i--) if (t[i]) k = i;
        exp_steps = uf ? 2 * W - 1 : 2 * k + 1;

        bus.load    = 1'b1;
        bus.tape_in = t;
        @(posedge clk); #1;
        bus.load = 1'b0;
        check("load_tape", 32'(bus.tape_out), 32'(t));
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        n          = 1;
        busy_cnt   = 0;
        obs2       = '0;
        prev_step  = 1'b1;
        prev_tape  = bus.tape_out;
        prev_steps = bus.steps;
        while (n <= 200) begin
            if (n == 2) obs2 = bus.tape_out;
            if (period > 1 && n >= 2 && !prev_step) begin
                check("frozen_tape", 32'(bus.tape_out), 32'(prev_tape));
                check("frozen_steps", 32'(bus.steps), 32'(prev_steps));
            end
            if (kind == 2 && n == 3) begin
                rst = 1'b1;
                #1;
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_done", 32'(bus.done), 32'd0);
                check("rst_uf", 32'(bus.underflow), 32'd0);
                check("rst_steps", 32'(bus.steps), 32'd0);
                check("rst_tape", 32'(bus.tape_out), 32'd0);
                rst = 1'b0;
                return;
            end
            if (kind == 1 && n == 3) begin
                bus.load    = 1'b1;
                bus.start   = 1'b1;
                bus.tape_in = 10'b0000000011;
            end
            if (kind == 1 && n == 4) begin
                bus.load  = 1'b0;
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
            prev_tape  = bus.tape_out;
            prev_steps = bus.steps;
`ifdef TURING_STEP_EN
            prev_step = bus.step;
            bus.step  = ((n % period) == 0);
`endif
            @(posedge clk); #1;
            n++;
        end
`ifdef TURING_STEP_EN
        bus.step = 1'b1;
`endif
        check("done_seen", 32'(n <= 200), 32'd1);
        if (period == 1) begin
            check("latency", 32'(n), 32'(exp_steps + 1));
            check("busy_cycles", 32'(busy_cnt), 32'(exp_steps + 1));
            check("cell0_write", 32'(obs2), 32'(t ^ 10'd1));
        end
        check("result", 32'(bus.tape_out), 32'(exp_t));
        check("steps", 32'(bus.steps), 32'(exp_steps));
        check("underflow", 32'(bus.underflow), 32'(uf));
        @(posedge clk); #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("busy_fall", 32'(bus.busy), 32'd0);
        check("uf_hold", 32'(bus.underflow), 32'(uf));
        check("steps_hold", 32'(bus.steps), 32'(exp_steps));
    endtask

    initial begin
        logic [W-1:0] t;
        int           k;

        bus.load    = 1'b0;
        bus.start   = 1'b0;
        bus.tape_in = '0;
`ifdef TURING_STEP_EN
        bus.step    = 1'b1;
`endif
        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_tape", 32'(bus.tape_out), 32'd0);
        check("reset_steps", 32'(bus.steps), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(10'b0111110110, 0, 1);
        run(10'b0000000001, 0, 1);
        run(10'b0000000000, 0, 1);
        run(10'b1000000000, 1, 1);
        run(10'b0000010000, 2, 1);
        run(10'b0000010000, 0, 1);

        for (int i = 0; i < 25; i++) begin
            k = int'($urandom_range(W, 0));
            t = W'($urandom);
            if (k == W) t = '0;
            else begin
                t = (t >> k) << k;
                t[k] = 1'b1;
            end
            run(t, 0, 1);
        end

`ifdef TURING_STEP_EN
        run(10'b0111110110, 0, 3);
        run(10'b0000000000, 0, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
